vga_line_fetch: RTL and testbench
=================================

VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 Parameters (name, default, meaning), SHALL be honoured:
- H_ACTIVE 640, visible pixels per line
- H_FP 16, H_SYNC 96, H_BP 48, horizontal porch and sync widths in clk cycles
- V_ACTIVE 480, visible lines
- V_FP 10, V_SYNC 2, V_BP 33, vertical porch and sync widths in lines
REQ-002 Ports (name, direction, width, meaning), SHALL be exactly:
- clk  in  1  pixel clock; also drives read_pixel_clk
- sys_rst_n  in  1  asynchronous, active-low reset
- frame_sel  in  2  frame buffer to display; sampled at frame start
- read_line_ack  in  1  line-fetch done, from the SDRAM clock domain
- underrun_clr  in  1  clears the underrun flag
- read_line_req  out  1  line-fetch request
- read_line_A_B  out  1  target buffer: 1 = A, 0 = B
- read_line_addr  out  16  line address
- read_pixel_addr  out  10  line-buffer read address
- read_pixel_clk  out  1  equals clk
- read_pixelA_data  in  16  buffer A read data, 1 clk latency
- read_pixelB_data  in  16  buffer B read data, 1 clk latency
- vga_hs, vga_vs  out  1 each  syncs, active-low
- vga_de  out  1  data enable
- vga_rgb  out  16  RGB565 pixel
- frame_start  out  1  one-clk pulse
- underrun  out  1  sticky fetch-late flag

Function
REQ-003 hcnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the four H parameters) and wrap to 0; vcnt SHALL increment on hcnt wrap and wrap at V_TOTAL-1.
REQ-004 Raw hs SHALL be low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); raw vs SHALL be low for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); raw de SHALL be (hcnt<H_ACTIVE && vcnt<V_ACTIVE).
REQ-005 read_pixel_addr SHALL equal hcnt[9:0] while raw de is 1, and 0 otherwise.
REQ-006 vga_hs, vga_vs and vga_de SHALL be the raw signals delayed 1 clk, to align with RAM latency.
REQ-007 vga_rgb SHALL be read_pixelA_data when the delayed row is even, read_pixelB_data when it is odd, and 16'h0000 whenever delayed de is 0; it SHALL be registered in the same stage as the delayed syncs.
REQ-008 Fetch point: at hcnt==H_ACTIVE of row vcnt, next line nl = (vcnt==V_TOTAL-1) ? 0 : vcnt+1; a fetch SHALL be launched only if nl < V_ACTIVE.
REQ-009 Fetch fields: read_line_addr = {4'b0, frame_lat, nl[9:0]}; read_line_A_B = ~nl[0]. Both SHALL be held stable while read_line_req is 1.
REQ-010 read_line_ack SHALL pass through a 2-flop synchronizer (ack_s) before any use.
REQ-011 Fetch FSM:
- IDLE: at a fetch point, load the fields, assert read_line_req, go to REQ.
- REQ: when ack_s==1, deassert read_line_req, go to DROP.
- DROP: when ack_s==0, go to IDLE.
REQ-012 A fetch point reached while the FSM is not in IDLE SHALL set underrun and SHALL NOT start a new request; the outstanding handshake SHALL complete normally.
REQ-013 underrun SHALL stay set until underrun_clr is 1; if a set event and underrun_clr occur in the same clk, set SHALL win.
REQ-014 frame_lat SHALL load frame_sel when hcnt==0 && vcnt==0; frame_start SHALL pulse high for that same single clk.
REQ-015 The line-0 fetch at row V_TOTAL-1 SHALL use frame_lat as already latched, i.e. the previous frame's selection.

Reset
REQ-016 While sys_rst_n is 0: hcnt, vcnt, frame_lat = 0; FSM = IDLE; read_line_req = 0; read_line_A_B = 0; read_line_addr = 0; read_pixel_addr = 0; vga_hs = 1; vga_vs = 1; vga_de = 0; vga_rgb = 0; frame_start = 0; underrun = 0; sync flops = 0.
REQ-017 Reset asserted mid-handshake SHALL drop read_line_req immediately; after release, the first fetch SHALL occur at the next fetch point.

Verification
REQ-018 Free-run 2 frames with ack responding 40 clks after req -> hs low for 96 clks every 800 clks; vs low for 2 lines every 525 lines; de high 640x480 per frame; underrun stays 0.
REQ-019 Row 524, hcnt=640, frame_sel=2 latched -> req with addr 16'h0800 and A_B=1; row 10 fetch -> addr 16'h080B, A_B=0.
REQ-020 Buffer A returns addr+1, B returns ~addr -> row 0 pixel 5 appears on vga_rgb 1 clk after read_pixel_addr=5 as 16'h0006; row 1 pixel 5 as 16'hFFFA.
REQ-021 Ack held off for 900 clks -> underrun=1 at the next fetch point and no second req edge; underrun_clr pulse -> underrun returns to 0.
REQ-022 sys_rst_n pulsed low while req=1 -> req=0 and all outputs at REQ-016 values asynchronously; normal timing resumes from hcnt=0, vcnt=0.
REQ-023 Rows 480..523 -> no req asserted; frame_start pulses exactly once per 420000 clks.

Source files
------------

// File: rtl/vga_line_fetch.sv
`timescale 1ns/1ps
// vga_line_fetch: VGA raster timing generator that prefetches each next
// display line from SDRAM into a ping-pong line buffer (A = even rows,
// B = odd rows) and streams RGB565 pixels out of the buffer.
// Ports:
//   clk, sys_rst_n          pixel clock, asynchronous active-low reset
//   frame_sel               frame buffer to display, latched at frame start
//   read_line_req/_ack      4-phase line-fetch handshake (ack from SDRAM domain)
//   read_line_A_B, _addr    target buffer (1 = A) and line address of the fetch
//   read_pixel_addr/_clk    line-buffer read port address and clock
//   read_pixelA/B_data      line-buffer read data
//   vga_hs, vga_vs, vga_de  syncs (active-low) and data enable, 1 clk late
//   vga_rgb                 RGB565 pixel, aligned with the syncs
//   frame_start             one-clk pulse at hcnt == 0, vcnt == 0
//   underrun                sticky flag: a fetch came due while one was pending
module vga_line_fetch #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [1:0]  frame_sel,
  input  logic        read_line_ack,
  input  logic        underrun_clr,
  output logic        read_line_req,
  output logic        read_line_A_B,
  output logic [15:0] read_line_addr,
  output logic [9:0]  read_pixel_addr,
  output logic        read_pixel_clk,
  input  logic [15:0] read_pixelA_data,
  input  logic [15:0] read_pixelB_data,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        frame_start,
  output logic        underrun
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CW      = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [CW-1:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt, nl;
  logic [1:0]    frame_lat;
  logic [1:0]    state, state_nxt;
  logic          ack_meta, ack_s;
  logic          hs_raw, vs_raw, de_raw, de_nxt;
  logic          fetch_pt, launch, late;

  assign read_pixel_clk = clk;

  // Raster counter advance.
  always_comb begin
    hcnt_nxt = hcnt + CW'(1);
    vcnt_nxt = vcnt;
    if (hcnt == CW'(H_TOTAL - 1)) begin
      hcnt_nxt = '0;
      vcnt_nxt = (vcnt == CW'(V_TOTAL - 1)) ? '0 : vcnt + CW'(1);
    end
  end

  // Raw (undelayed) timing signals for the current counter position.
  always_comb begin
    hs_raw = !((hcnt >= CW'(H_ACTIVE + H_FP)) && (hcnt < CW'(H_ACTIVE + H_FP + H_SYNC)));
    vs_raw = !((vcnt >= CW'(V_ACTIVE + V_FP)) && (vcnt < CW'(V_ACTIVE + V_FP + V_SYNC)));
    de_raw = (hcnt < CW'(H_ACTIVE)) && (vcnt < CW'(V_ACTIVE));
    de_nxt = (hcnt_nxt < CW'(H_ACTIVE)) && (vcnt_nxt < CW'(V_ACTIVE));
  end

  // Fetch point: end of active video, prefetch the following line if visible.
  always_comb begin
    nl       = (vcnt == CW'(V_TOTAL - 1)) ? '0 : vcnt + CW'(1);
    fetch_pt = (hcnt == CW'(H_ACTIVE)) && (nl < CW'(V_ACTIVE));
  end

  // Fetch FSM next state; a fetch point outside IDLE is an underrun.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    late      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fetch_pt) begin
          launch    = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        late = fetch_pt;
        if (ack_s) state_nxt = ST_DROP;
      end
      ST_DROP: begin
        late = fetch_pt;
        if (!ack_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Counters, ack synchronizer, fetch fields and the video output stage.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hcnt            <= '0;
      vcnt            <= '0;
      frame_lat       <= '0;
      ack_meta        <= 1'b0;
      ack_s           <= 1'b0;
      read_line_req   <= 1'b0;
      read_line_A_B   <= 1'b0;
      read_line_addr  <= '0;
      read_pixel_addr <= '0;
      vga_hs          <= 1'b1;
      vga_vs          <= 1'b1;
      vga_de          <= 1'b0;
      vga_rgb         <= '0;
      frame_start     <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      hcnt     <= hcnt_nxt;
      vcnt     <= vcnt_nxt;
      ack_meta <= read_line_ack;
      ack_s    <= ack_meta;
      if ((hcnt == '0) && (vcnt == '0)) frame_lat <= frame_sel;
      read_line_req <= (state_nxt == ST_REQ);
      if (launch) begin
        read_line_addr <= {4'b0, frame_lat, nl[9:0]};
        read_line_A_B  <= ~nl[0];
      end
      // Registered from the next count so the address tracks hcnt exactly.
      read_pixel_addr <= de_nxt ? hcnt_nxt[9:0] : 10'd0;
      frame_start     <= (hcnt_nxt == '0) && (vcnt_nxt == '0);
      vga_hs          <= hs_raw;
      vga_vs          <= vs_raw;
      vga_de          <= de_raw;
      // Buffer read data follows read_pixel_addr; this register is the one
      // clk of latency that the delayed syncs line up with.
      vga_rgb <= de_raw ? (vcnt[0] ? read_pixelB_data : read_pixelA_data) : 16'h0000;
      if (late)              underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
`timescale 1ns/1ps
// tb_vga_line_fetch: self-checking bench for vga_line_fetch on a reduced
// raster (80 x 19 clks per frame) with an SDRAM-side ack responder and a
// line buffer returning addr+1 (A) and ~addr (B).
module tb_vga_line_fetch;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic [1:0]  frame_sel;
  logic        read_line_ack;
  logic        underrun_clr;
  logic        read_line_req;
  logic        read_line_A_B;
  logic [15:0] read_line_addr;
  logic [9:0]  read_pixel_addr;
  logic        read_pixel_clk;
  logic [15:0] read_pixelA_data;
  logic [15:0] read_pixelB_data;
  logic        vga_hs, vga_vs, vga_de;
  logic [15:0] vga_rgb;
  logic        frame_start;
  logic        underrun;

  vga_line_fetch #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk              (clk),
    .sys_rst_n        (sys_rst_n),
    .frame_sel        (frame_sel),
    .read_line_ack    (read_line_ack),
    .underrun_clr     (underrun_clr),
    .read_line_req    (read_line_req),
    .read_line_A_B    (read_line_A_B),
    .read_line_addr   (read_line_addr),
    .read_pixel_addr  (read_pixel_addr),
    .read_pixel_clk   (read_pixel_clk),
    .read_pixelA_data (read_pixelA_data),
    .read_pixelB_data (read_pixelB_data),
    .vga_hs           (vga_hs),
    .vga_vs           (vga_vs),
    .vga_de           (vga_de),
    .vga_rgb          (vga_rgb),
    .frame_start      (frame_start),
    .underrun         (underrun)
  );

  always #5 clk = ~clk;

  // Line-buffer model.
  assign read_pixelA_data = 16'(read_pixel_addr) + 16'd1;
  assign read_pixelB_data = ~16'(read_pixel_addr);

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference raster position and frame selection.
  int         m_h = 0;
  int         m_v = 0;
  int         cyc = 0;
  logic [1:0] m_frame = 2'd0;

  always @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_h     <= 0;
      m_v     <= 0;
      cyc     <= 0;
      m_frame <= 2'd0;
    end else begin
      cyc <= cyc + 1;
      if (m_h == 0 && m_v == 0) m_frame <= frame_sel;
      if (m_h == HT - 1) begin
        m_h <= 0;
        m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h <= m_h + 1;
      end
    end
  end

  // Scoreboard: expected video/fetches pushed from the model, popped on output.
  logic [18:0] vq[$];
  logic [16:0] fq[$];
  logic [18:0] vexp;
  logic [16:0] held;
  logic        held_ok = 1'b0;
  logic        req_q = 1'b0;
  logic        e_de;
  bit          sb_en = 1'b1;
  int          nl;
  int          req_rises = 0;

  always @(negedge clk) begin
    if (!sys_rst_n) begin
      vq.delete();
      fq.delete();
      req_q   = 1'b0;
      held_ok = 1'b0;
    end else begin
      if (vq.size() > 0) begin
        vexp = vq.pop_front();
        check("video", 32'({vga_hs, vga_vs, vga_de, vga_rgb}), 32'(vexp));
      end
      e_de = (m_h < HA) && (m_v < VA);
      check("pix_addr", 32'(read_pixel_addr), e_de ? 32'(m_h) : 32'd0);
      check("frame_start", 32'(frame_start), 32'(m_h == 0 && m_v == 0 && cyc > 0));
      vq.push_back({!(m_h >= HA + HF && m_h < HA + HF + HS),
                    !(m_v >= VA + VF && m_v < VA + VF + VS),
                    e_de,
                    e_de ? (m_v[0] ? ~16'(m_h) : 16'(m_h + 1)) : 16'h0000});
      if (sb_en && m_h == HA) begin
        nl = (m_v == VT - 1) ? 0 : m_v + 1;
        if (nl < VA) begin
          check("fetch_missing", 32'(fq.size()), 32'd0);
          fq.push_back({4'b0, m_frame, 10'(nl), ~nl[0]});
        end
      end
      if (read_line_req && !req_q) begin
        req_rises++;
        if (sb_en) begin
          check("req_expected", 32'(fq.size() > 0), 32'd1);
          if (fq.size() > 0) begin
            held    = fq.pop_front();
            held_ok = 1'b1;
            check("fetch_fields", 32'({read_line_addr, read_line_A_B}), 32'(held));
          end
        end
      end else if (read_line_req && held_ok) begin
        check("fetch_hold", 32'({read_line_addr, read_line_A_B}), 32'(held));
      end
      if (!read_line_req) held_ok = 1'b0;
      req_q = read_line_req;
    end
  end

  // SDRAM-side responder: ack ack_delay clks after req, drop after req drops.
  int ack_delay = 40;
  int resp_d;

  initial begin
    read_line_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!sys_rst_n) begin
        read_line_ack = 1'b0;
      end else if (read_line_req && !read_line_ack) begin
        resp_d = ack_delay;
        for (int i = 1; i < resp_d && read_line_req && sys_rst_n; i++) @(negedge clk);
        if (read_line_req && sys_rst_n) read_line_ack = 1'b1;
      end else if (!read_line_req) begin
        read_line_ack = 1'b0;
      end
    end
  end

  task automatic wait_pos(input int v, input int h, input string tag);
    int n = 0;
    while (!(m_v == v && m_h == h) && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(m_v == v && m_h == h), 32'd1);
  endtask

  int hs_lo, vs_lo, de_hi, fs_n, ur_n;

  initial begin
    sys_rst_n    = 1'b0;
    frame_sel    = 2'd2;
    underrun_clr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_hs", 32'(vga_hs), 32'd1);
    check("rst_vs", 32'(vga_vs), 32'd1);
    check("rst_de", 32'(vga_de), 32'd0);
    check("rst_rgb", 32'(vga_rgb), 32'd0);
    check("rst_req", 32'(read_line_req), 32'd0);
    check("rst_line_addr", 32'(read_line_addr), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("pixel_clk", 32'(read_pixel_clk), 32'(clk));
    sys_rst_n = 1'b1;

    // Two free-running frames with 40-clk ack latency.
    repeat (2) @(negedge clk);
    hs_lo = 0; vs_lo = 0; de_hi = 0; fs_n = 0; ur_n = 0;
    req_rises = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (!vga_hs) hs_lo++;
      if (!vga_vs) vs_lo++;
      if (vga_de) de_hi++;
      if (frame_start) fs_n++;
      if (underrun) ur_n++;
    end
    check("hs_low_clks", 32'(hs_lo), 32'(2 * VT * HS));
    check("vs_low_clks", 32'(vs_lo), 32'(2 * VS * HT));
    check("de_high_clks", 32'(de_hi), 32'(2 * HA * VA));
    check("frame_starts", 32'(fs_n), 32'd2);
    check("underrun_free_run", 32'(ur_n), 32'd0);
    check("req_per_2_frames", 32'(req_rises), 32'(2 * VA));

    // Frame selection: row 10 and the line-0 fetch of the next frame.
    wait_pos(10, HA + 2, "wait_row10");
    check("row10_req", 32'(read_line_req), 32'd1);
    check("row10_addr", 32'(read_line_addr), 32'h080B);
    check("row10_ab", 32'(read_line_A_B), 32'd0);
    frame_sel = 2'd1;
    wait_pos(VT - 1, HA + 2, "wait_last_row");
    check("line0_addr_prev_frame", 32'(read_line_addr), 32'h0800);
    check("line0_ab", 32'(read_line_A_B), 32'd1);
    wait_pos(10, HA + 2, "wait_row10_b");
    check("row10_addr_frame1", 32'(read_line_addr), 32'h040B);

    // Pixel path: even row from buffer A, odd row from buffer B.
    wait_pos(0, 5, "wait_px_r0");
    check("px_addr_r0", 32'(read_pixel_addr), 32'd5);
    @(negedge clk);
    check("px_rgb_r0", 32'(vga_rgb), 32'h0006);
    wait_pos(1, 5, "wait_px_r1");
    check("px_addr_r1", 32'(read_pixel_addr), 32'd5);
    @(negedge clk);
    check("px_rgb_r1", 32'(vga_rgb), 32'hFFFA);

    // Underrun: ack held off across two fetch points.
    wait_pos(3, 40, "wait_ur_start");
    sb_en     = 1'b0;
    ack_delay = 200;
    req_rises = 0;
    wait_pos(4, HA + 2, "wait_ur_set");
    check("underrun_set", 32'(underrun), 32'd1);
    check("req_still_high", 32'(read_line_req), 32'd1);
    wait_pos(5, 60, "wait_ur_clr");
    underrun_clr = 1'b1;
    @(negedge clk);
    check("underrun_cleared", 32'(underrun), 32'd0);
    wait_pos(5, HA + 1, "wait_ur_setwins");
    check("underrun_set_wins", 32'(underrun), 32'd1);
    check("no_second_req", 32'(req_rises), 32'd1);
    @(negedge clk);
    underrun_clr = 1'b0;
    ack_delay    = 40;
    check("underrun_clr_after", 32'(underrun), 32'd0);
    wait_pos(7, 40, "wait_ur_end");
    sb_en = 1'b1;
    wait_pos(7, HA + 2, "wait_ur_recover");
    check("recover_req", 32'(read_line_req), 32'd1);
    check("recover_underrun", 32'(underrun), 32'd0);

    // Reset in the middle of a handshake.
    wait_pos(8, 10, "wait_rst_point");
    check("req_before_rst", 32'(read_line_req), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_req", 32'(read_line_req), 32'd0);
    check("arst_addr", 32'(read_line_addr), 32'd0);
    check("arst_ab", 32'(read_line_A_B), 32'd0);
    check("arst_pix_addr", 32'(read_pixel_addr), 32'd0);
    check("arst_de", 32'(vga_de), 32'd0);
    check("arst_rgb", 32'(vga_rgb), 32'd0);
    check("arst_hs_vs", 32'({vga_hs, vga_vs}), 32'd3);
    @(negedge clk);
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
    req_rises = 0;
    wait_pos(0, HA + 2, "wait_post_rst_fetch");
    check("post_rst_req", 32'(read_line_req), 32'd1);
    check("post_rst_addr", 32'(read_line_addr), 32'h0401);
    check("post_rst_ab", 32'(read_line_A_B), 32'd0);
    check("post_rst_first_req", 32'(req_rises), 32'd1);

    repeat (HT) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
